i2c_master_arbiter: RTL and testbench

- Shares one i2c master between NREQ client requesters and sequences each single-byte transaction on it.
- Grants round-robin and loads rw/data_in into the master.
- Releases the master from reset to run one transfer, detects completion from the master's state output, returns read data, and recovers via timeout if the master hangs.
- Sits between client logic and the master instance; the master's rst is driven only by this block.

---
 rtl/i2c_master_arbiter.sv | 161 ++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin front end that shares one i2c master
// among NREQ clients. Each grant loads rw/data into the master, releases
// the master from reset for one transfer, and waits for the master to
// reach STOP or for the timeout to expire.
module i2c_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_rw,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              done,
  output logic [IDW-1:0]    done_id,
  output logic              err,
  output logic [7:0]        rdata,
  output logic              m_rst,
  output logic              m_rw,
  output logic [7:0]        m_data_in,
  input  logic [7:0]        m_data_out,
  input  logic [3:0]        m_state
);

  localparam logic [3:0] M_STOP = 4'd9;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [IDW-1:0]  done_id_q, done_id_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            m_rst_q, m_rst_d;
  logic            m_rw_q, m_rw_d;
  logic [7:0]      m_data_q, m_data_d;
  logic [TW-1:0]   cnt_q, cnt_d;

  logic [IDW-1:0]  sel;
  logic            found;

  // Round-robin pick: first set req bit after the last-granted index, wrapping.
  always_comb begin
    int idx;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  // Next-state and registered-output logic for the transaction sequencer.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    done_id_d = done_id_q;
    rdata_d   = rdata_q;
    m_rst_d   = m_rst_q;
    m_rw_d    = m_rw_q;
    m_data_d  = m_data_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_GRANT;
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          ptr_d      = sel;
          m_rw_d     = req_rw[sel];
          m_data_d   = req_wdata[{sel, 3'b000} +: 8];
        end
      end
      S_GRANT: begin
        state_d = S_RUN;
        m_rst_d = 1'b0;
        cnt_d   = '0;
      end
      S_RUN: begin
        cnt_d = cnt_q + TW'(1);
        // Completion is checked first so it wins a same-cycle timeout.
        if (m_state == M_STOP) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          done_id_d = ptr_q;
          m_rst_d   = 1'b1;
          if (m_rw_q) rdata_d = m_data_out;
        end else if (cnt_q == TW'(TIMEOUT)) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          err_d     = 1'b1;
          done_id_d = ptr_q;
          m_rst_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset parks the master in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= IDW'(NREQ - 1);
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      done_id_q <= '0;
      rdata_q   <= '0;
      m_rst_q   <= 1'b1;
      m_rw_q    <= 1'b0;
      m_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      done_id_q <= done_id_d;
      rdata_q   <= rdata_d;
      m_rst_q   <= m_rst_d;
      m_rw_q    <= m_rw_d;
      m_data_q  <= m_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign done_id   = done_id_q;
  assign rdata     = rdata_q;
  assign m_rst     = m_rst_q;
  assign m_rw      = m_rw_q;
  assign m_data_in = m_data_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter with a counting master model.
module tb_i2c_master_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_rw;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   gnt;
  logic              busy, done, err;
  logic [IDW-1:0]    done_id;
  logic [7:0]        rdata;
  logic              m_rst, m_rw;
  logic [7:0]        m_data_in, m_data_out;
  logic [3:0]        m_state;

  logic       hang;
  logic [7:0] rd_byte;
  logic [3:0] mst;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           er;
    logic [7:0]     rd;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  i2c_master_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(20), .TW(10)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rw(req_rw), .req_wdata(req_wdata),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .err(err),
    .rdata(rdata), .m_rst(m_rst), .m_rw(m_rw), .m_data_in(m_data_in),
    .m_data_out(m_data_out), .m_state(m_state)
  );

  always #5 clk = ~clk;

  // Master stand-in: walks 0..9 once out of reset, or sticks at 3 when hung.
  always @(posedge clk or posedge m_rst) begin
    if (m_rst)                  mst <= 4'd0;
    else if (hang && mst == 3)  mst <= mst;
    else if (mst != 4'd9)       mst <= mst + 4'd1;
  end
  assign m_state    = mst;
  assign m_data_out = rd_byte;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) chk("unexp_done", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        chk("done_id", 32'(done_id), 32'(e.id));
        chk("err", 32'(err), 32'(e.er));
        chk("rdata", 32'(rdata), 32'(e.rd));
        chk("m_rst_at_done", 32'(m_rst), 32'd1);
      end
    end
  end

  // Grant must be one-hot throughout any transaction.
  always @(negedge clk) begin
    if (!rst && busy) chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin cyc(1); n++; end
    if (!done) chk(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (m_rst && n < 50) begin cyc(1); n++; end
    if (m_rst) chk(tag, 32'd1, 32'd0);
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; req = '0; req_rw = '0; req_wdata = '0; hang = 1'b0; rd_byte = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_done_id", 32'(done_id), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_m_rst", 32'(m_rst), 32'd1);
    chk("rst_m_rw", 32'(m_rw), 32'd0);
    chk("rst_m_data", 32'(m_data_in), 32'd0);
    rst = 1'b0;

    // Write from requester 0
    req = 4'b0001; req_wdata[7:0] = 8'hA6; sbq.push_back('{2'd0, 1'b0, 8'h00});
    cyc(1);
    chk("w_gnt", 32'(gnt), 32'h1);
    chk("w_data", 32'(m_data_in), 32'hA6);
    chk("w_rw", 32'(m_rw), 32'd0);
    chk("w_busy", 32'(busy), 32'd1);
    chk("w_mrst_grant", 32'(m_rst), 32'd1);
    req = '0;
    cyc(1);
    chk("w_mrst_run", 32'(m_rst), 32'd0);
    wait_done("w_done_wait");
    cyc(2);
    chk("w_idle_busy", 32'(busy), 32'd0);

    // Read from requester 2
    rd_byte = 8'hF6; req_rw = 4'b0100; req = 4'b0100; sbq.push_back('{2'd2, 1'b0, 8'hF6});
    cyc(1);
    chk("r_gnt", 32'(gnt), 32'h4);
    chk("r_rw", 32'(m_rw), 32'd1);
    req = '0;
    wait_done("r_done_wait");
    cyc(2);

    // Round-robin with all requests held, from a fresh pointer
    pulse_rst();
    req_rw = '0; req = 4'b1111;
    for (int i = 0; i < 5; i++) sbq.push_back('{IDW'(i % 4), 1'b0, 8'h00});
    cyc(1);
    chk("rr_first", 32'(gnt), 32'h1);
    for (int i = 0; i < 5; i++) begin
      wait_done("rr_done_wait");
      if (i == 4) req = '0;
      cyc(1);
      chk("rr_gap", 32'(gnt), 32'd0);
      if (i < 4) begin
        cyc(1);
        chk("rr_next", 32'(gnt), 32'(1 << ((i + 1) % 4)));
      end
    end
    cyc(2);

    // Timeout on a hung read; rdata must not load
    hang = 1'b1; rd_byte = 8'h5A; req_rw = 4'b0001; req = 4'b0001;
    sbq.push_back('{2'd0, 1'b1, 8'h00});
    cyc(1);
    req = '0;
    wait_run("to_run_wait");
    n = 0;
    while (!done && n < 100) begin cyc(1); n++; end
    chk("to_latency", 32'(n), 32'd21);
    hang = 1'b0;
    cyc(2);
    rd_byte = 8'h3C; req_rw = 4'b0010; req = 4'b0010;
    sbq.push_back('{2'd1, 1'b0, 8'h3C});
    cyc(1);
    chk("to_next_gnt", 32'(gnt), 32'h2);
    req = '0;
    wait_done("to_next_wait");
    cyc(2);

    // Asynchronous reset in the middle of RUN
    req_rw = '0; req = 4'b0100;
    cyc(1);
    chk("ar_gnt", 32'(gnt), 32'h4);
    req = '0;
    wait_run("ar_run_wait");
    cyc(5);
    #1 rst = 1'b1;
    #1;
    chk("ar_gnt0", 32'(gnt), 32'd0);
    chk("ar_mrst", 32'(m_rst), 32'd1);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0010; sbq.push_back('{2'd1, 1'b0, 8'h00});
    cyc(1);
    chk("ar_post_gnt", 32'(gnt), 32'h2);
    req = '0;
    wait_done("ar_post_wait");
    cyc(2);

    // Requester 1 drops its request mid-transfer
    pulse_rst();
    req = 4'b0110;
    sbq.push_back('{2'd1, 1'b0, 8'h00});
    sbq.push_back('{2'd2, 1'b0, 8'h00});
    cyc(1);
    chk("drop_gnt", 32'(gnt), 32'h2);
    wait_run("drop_run_wait");
    req = 4'b0100;
    wait_done("drop_done_wait");
    cyc(2);
    chk("drop_next", 32'(gnt), 32'h4);
    req = '0;
    wait_done("drop_next_wait");
    cyc(2);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
